// File: rtl/register_bank.sv
// Sixteen-entry register file: three operand read ports, a store-data read port,
// one write-back port, a link write into R14 and an unconditional PC reload of R15.
module register_bank #(
  parameter int bus     = 32,
  parameter int dir     = 4,
  parameter int reg_num = 2**dir
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [dir-1:0] RD,
  input  logic [dir-1:0] RS,
  input  logic [dir-1:0] RX,
  input  logic [dir-1:0] RK,
  input  logic [bus-1:0] WB,
  input  logic [bus-1:0] PCi,
  input  logic           WE,
  input  logic           RE,
  input  logic           LKN,
  output logic [bus-1:0] StrReg,
  output logic [bus-1:0] RSd,
  output logic [bus-1:0] RXd,
  output logic [bus-1:0] RKd,
  output logic [bus-1:0] PCo
);

  localparam int pc_idx = reg_num - 1;
  localparam int lk_idx = reg_num - 2;

  logic [bus-1:0] rf [reg_num];

  genvar gi;
  generate
    for (gi = 0; gi < reg_num; gi++) begin : g_reg
      logic [bus-1:0] q_reg;
      logic [bus-1:0] q_next;

      if (gi == pc_idx) begin : g_pc
        // PC reload always wins, so a write-back aimed at R15 is dropped
        always_comb q_next = PCi;
      end else if (gi == lk_idx) begin : g_link
        always_comb begin
          q_next = q_reg;
          if (LKN)
            q_next = PCi;
          else if (WE && (RD == dir'(gi)))
            q_next = WB;
        end
      end else begin : g_gp
        always_comb begin
          q_next = q_reg;
          if (WE && (RD == dir'(gi)))
            q_next = WB;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          q_reg <= '0;
        else
          q_reg <= q_next;
      end

      assign rf[gi] = q_reg;
    end
  endgenerate

  // Reads come straight from the array; a same-cycle write is not forwarded
  assign RSd    = RE ? rf[RS] : '0;
  assign RXd    = RE ? rf[RX] : '0;
  assign RKd    = RE ? rf[RK] : '0;
  assign StrReg = RE ? rf[RD] : '0;
  assign PCo    = rf[pc_idx];

endmodule

// File: tb/tb_register_bank.sv
// Directed and randomized checks of register_bank against an array-based model.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  RD, RS, RX, RK;
  logic [31:0] WB, PCi;
  logic        WE, RE, LKN;
  logic [31:0] StrReg, RSd, RXd, RKd, PCo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [16];

  register_bank dut (
    .clk(clk), .rst_n(rst_n), .RD(RD), .RS(RS), .RX(RX), .RK(RK),
    .WB(WB), .PCi(PCi), .WE(WE), .RE(RE), .LKN(LKN),
    .StrReg(StrReg), .RSd(RSd), .RXd(RXd), .RKd(RKd), .PCo(PCo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [3:0] a);
    return RE ? model[a] : 32'h0;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".RSd"},    RSd,    rd_model(RS));
    chk({tag, ".RXd"},    RXd,    rd_model(RX));
    chk({tag, ".RKd"},    RKd,    rd_model(RK));
    chk({tag, ".StrReg"}, StrReg, rd_model(RD));
    chk({tag, ".PCo"},    PCo,    model[15]);
  endtask

  // Apply one rising edge to the model, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (WE && RD != 4'd15 && !(LKN && RD == 4'd14)) model[RD] = WB;
      if (LKN) model[14] = PCi;
      model[15] = PCi;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; RD = 0; RS = 0; RX = 0; RK = 0;
    WB = 0; PCi = 0; WE = 0; RE = 1'b1; LKN = 0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    #12;
    chk_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1 chk_all("post_reset");
    chk("post_reset.PCo_zero", PCo, 32'h0);

    // write sweep R0..R14
    for (int i = 0; i < 15; i++) begin
      WE = 1'b1; RD = 4'(i); WB = 32'hA5A50000 + i;
      tick();
      $display("write R%0d <= %h", i, WB);
    end
    WE = 0; RS = 4'd3; RX = 4'd7; RK = 4'd14; RD = 4'd0;
    #1;
    chk("sweep.RSd", RSd, 32'hA5A50003);
    chk("sweep.RXd", RXd, 32'hA5A50007);
    chk("sweep.RKd", RKd, 32'hA5A5000E);
    chk("sweep.StrReg", StrReg, 32'hA5A50000);
    chk_all("sweep");

    // PC reload and priority over write-back
    PCi = 32'h40;
    tick();
    #1 chk("pc.load", PCo, 32'h40);
    WE = 1'b1; RD = 4'd15; WB = 32'hDEADBEEF; PCi = 32'h44;
    tick();
    WE = 0; RS = 4'd15;
    #1 chk("pc.prio_PCo", PCo, 32'h44);
    chk("pc.prio_RSd", RSd, 32'h44);
    $display("pc write attempt: PCo=%h", PCo);

    // link beats write-back to R14
    WE = 1'b1; RD = 4'd14; WB = 32'h11111111; LKN = 1'b1; PCi = 32'h80;
    tick();
    WE = 0; LKN = 0; RK = 4'd14;
    #1 chk("link.RKd", RKd, 32'h80);
    chk_all("link");

    // read gating and lack of bypass
    WE = 1'b1; RD = 4'd5; WB = 32'h12345678;
    tick();
    WE = 0; RE = 0; RS = 4'd5;
    #1 chk("gate.RSd", RSd, 32'h0);
    chk("gate.PCo", PCo, model[15]);
    chk_all("gate");
    RE = 1'b1; WE = 1'b1; RD = 4'd5; WB = 32'h0BADF00D;
    #1 chk("nobypass.before", RSd, 32'h12345678);
    tick();
    WE = 0;
    #1 chk("nobypass.after", RSd, 32'h0BADF00D);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      RD = 4'($urandom_range(15)); RS = 4'($urandom_range(15));
      RX = 4'($urandom_range(15)); RK = 4'($urandom_range(15));
      WB = $urandom; PCi = $urandom;
      WE = 1'($urandom); LKN = ($urandom_range(3) == 0);
      RE = ($urandom_range(4) != 0);
      #1 chk_all("rand");
      $display("rand %0d: WE=%0b RD=%0d LKN=%0b RE=%0b RS=%0d RSd=%h", n, WE, RD, LKN, RE, RS, RSd);
      tick();
    end

    // asynchronous reset between edges
    WE = 0; LKN = 0; RE = 1'b1;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    #1 chk_all("async_rst");
    chk("async_rst.PCo", PCo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; PCi = 32'h100;
    tick();
    #1 chk("after_rst.PCo", PCo, 32'h100);
    chk_all("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_bank.md
# register_bank

Sixteen-entry, 32-bit general-purpose register file for the processor datapath, sitting between decode and execute. Provides three combinational operand read ports (RS, RX, RK) and a store-data read port (RD). Provides one synchronous write port for write-back and a dedicated link write. Register 15 is the program counter, reloaded every cycle from the fetch stage.

## Interface
Parameters:
- bus, 32, data width of every register and data port
- dir, 4, register address width
- reg_num, 2**dir (16), number of registers

Ports:
- Clocking is fixed: one clock; reset is asynchronous and active-low.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- RD  input  dir  destination address for the write-back port; also the read address for StrReg
- RS  input  dir  operand read address S
- RX  input  dir  operand read address X
- RK  input  dir  operand read address K
- WB  input  bus  write-back data, written to register RD
- PCi  input  bus  next program counter from fetch
- WE  input  1  write enable for the WB→RD write
- RE  input  1  read enable for all four data read ports
- LKN  input  1  link: capture PCi into R14
- StrReg  output  bus  contents of register RD (store data)
- RSd  output  bus  contents of register RS
- RXd  output  bus  contents of register RX
- RKd  output  bus  contents of register RK
- PCo  output  bus  contents of R15 (current PC)

## Operation
- Storage: reg_num × bus flip-flop array, R0..R15. R0 is an ordinary register and is not hardwired to zero. R14 is the link register. R15 is the PC.
- Reset (rst_n=0, asynchronous): all 16 registers clear to 0. While reset is asserted, all outputs are 0.
- PC update: on every rising edge out of reset, R15 ← PCi, unconditionally.
- Write-back: on a rising edge with WE=1, R[RD] ← WB. If RD=15, the write is ignored because the PC load has priority.
- Link: on a rising edge with LKN=1, R14 ← PCi.
  - If WE=1 and RD=14 in the same cycle, LKN wins.
  - If WE=1 and RD≠14, both writes occur.
- Reads are purely combinational from the array, with no write bypass:
  - RE=1: RSd=R[RS], RXd=R[RX], RKd=R[RK], StrReg=R[RD].
  - RE=0: RSd, RXd, RKd and StrReg are all 0.
  - PCo=R15 at all times, independent of RE.
- Reading address 15 on any port returns the current PC; reading address 14 returns the link value.
- The same address may appear on several read ports at once; each port returns the same value.

## Timing
- Read latency 0: outputs follow the address inputs and RE combinationally within the same cycle.
- Write latency 1: a value written at edge N is visible on the read ports after edge N. During the write cycle itself, reads return the old value.
- PCo shows the PCi sampled at the previous rising edge.
- Reset asserted mid-cycle clears all registers immediately, without waiting for clk. The first update after release occurs at the first rising edge with rst_n=1.

## Test plan
- Reset, then release with RE=1 and every address 0 → all of StrReg, RSd, RXd, RKd and PCo equal 0x00000000.
- Write sweep: WE=1, RD=i, WB=0xA5A50000+i for i=0..14, then read with RS=3, RX=7, RK=14, RD=0 and RE=1 → RSd=0xA5A50003, RXd=0xA5A50007, RKd=0xA5A5000E, StrReg=0xA5A50000.
- PC and write priority:
  - PCi=0x00000040 for one edge → PCo=0x00000040.
  - Next cycle: WE=1, RD=15, WB=0xDEADBEEF, PCi=0x00000044 → PCo=0x00000044 and R15 ≠ 0xDEADBEEF.
- Link priority: WE=1, RD=14, WB=0x11111111, LKN=1, PCi=0x00000080 → RKd (RK=14) reads 0x00000080.
- Read gating and no bypass:
  - With R5=0x12345678, RE=0 → RSd=0 for RS=5, while PCo is unaffected.
  - Set RE=1 and issue WE=1, RD=5, WB=0x0BADF00D with RS=5 → RSd=0x12345678 before the edge and 0x0BADF00D after it.
- Asynchronous reset mid-operation: with registers loaded, pull rst_n low between clock edges → every output reads 0 with no clock edge required.
